// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the IF stage: a PHT of saturating counters,
// a tagged direct-mapped BTB and an optional global history register
// (gshare when GHR_BITS > 0, bimodal when GHR_BITS = 0).
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   if_valid         IF holds an unstalled branch-class instruction
//   if_pc            PC being fetched
//   predict_taken    predicted taken (BTB hit and counter MSB set)
//   predict_hit      BTB hit for if_pc
//   predict_target   BTB target, meaningful only when predict_hit = 1
//   predict_ghr      history snapshot used for this lookup
//   upd_valid        a branch resolved this cycle
//   upd_pc           PC of the resolved branch
//   upd_ghr          predict_ghr captured at that branch's lookup
//   upd_taken        actual outcome
//   upd_target       actual taken target
//   upd_mispredict   prediction was wrong (qualified by upd_valid)
module branch_predictor #(
   parameter int ENTRIES  = 64,
   parameter int CTR_BITS = 2,
   parameter int TAG_BITS = 8,
   parameter int GHR_BITS = 0
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         if_valid,
   input  logic [31:0]                                  if_pc,
   output logic                                         predict_taken,
   output logic                                         predict_hit,
   output logic [31:0]                                  predict_target,
   output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0]   predict_ghr,
   input  logic                                         upd_valid,
   input  logic [31:0]                                  upd_pc,
   input  logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0]   upd_ghr,
   input  logic                                         upd_taken,
   input  logic [31:0]                                  upd_target,
   input  logic                                         upd_mispredict
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int GW    = (GHR_BITS > 0) ? GHR_BITS : 1;
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   // Weakly not-taken: 2^(CTR_BITS-1)-1, which is 0 for 1-bit counters.
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

   logic [CTR_BITS-1:0] pht        [ENTRIES];
   logic [ENTRIES-1:0]  btb_valid;
   logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
   logic [31:0]         btb_target [ENTRIES];
   logic [GW-1:0]       ghr;

   logic [IDX_W-1:0]    lk_idx, lk_pht_idx, up_idx, up_pht_idx;
   logic [TAG_BITS-1:0] lk_tag, up_tag;

   // gshare hash; history is zero-extended into the index width.
   function automatic logic [IDX_W-1:0] pht_hash(input logic [IDX_W-1:0] idx,
                                                 input logic [GW-1:0]    hist);
      logic [IDX_W-1:0] ext;
      ext = '0;
      if (GHR_BITS > 0) ext[GW-1:0] = hist;
      return idx ^ ext;
   endfunction

   assign lk_idx     = if_pc[IDX_W+1:2];
   assign lk_tag     = if_pc[IDX_W+TAG_BITS+1:IDX_W+2];
   assign lk_pht_idx = pht_hash(lk_idx, ghr);
   assign up_idx     = upd_pc[IDX_W+1:2];
   assign up_tag     = upd_pc[IDX_W+TAG_BITS+1:IDX_W+2];
   assign up_pht_idx = pht_hash(up_idx, upd_ghr);

   // Lookup reads the registered tables directly, so a same-cycle update
   // is only visible from the following cycle.
   assign predict_hit    = btb_valid[lk_idx] & (btb_tag[lk_idx] == lk_tag);
   assign predict_taken  = predict_hit & pht[lk_pht_idx][CTR_BITS-1];
   assign predict_target = btb_target[lk_idx];
   assign predict_ghr    = ghr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) pht[i] <= CTR_INIT;
      end else if (upd_valid) begin
         if (upd_taken) begin
            if (pht[up_pht_idx] != CTR_MAX) pht[up_pht_idx] <= pht[up_pht_idx] + 1'b1;
         end else begin
            if (pht[up_pht_idx] != '0) pht[up_pht_idx] <= pht[up_pht_idx] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         btb_valid <= '0;
      else if (upd_valid && upd_taken)
         btb_valid[up_idx] <= 1'b1;
   end

   // Tag and target are qualified by btb_valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (upd_valid && upd_taken) begin
         btb_tag[up_idx]    <= up_tag;
         btb_target[up_idx] <= upd_target;
      end
   end

   generate
      if (GHR_BITS > 0) begin : g_ghr
         // Repair from the resolved branch's snapshot beats speculation.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               ghr <= '0;
            else if (upd_valid && upd_mispredict)
               ghr <= (upd_ghr << 1) | GW'(upd_taken);
            else if (if_valid)
               ghr <= (ghr << 1) | GW'(predict_taken);
         end
      end else begin : g_no_ghr
         assign ghr = '0;
      end
   endgenerate

   // Upper/lower PC bits and, in bimodal mode, the history inputs are unused.
   logic unused_bits;
   assign unused_bits = ^{if_pc, upd_pc, upd_ghr, upd_mispredict, if_valid};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispredict;
   logic        upd_ghr1;
   logic [3:0]  upd_ghr4;

   logic        tk_b, hit_b, tk_g, hit_g;
   logic [31:0] tgt_b, tgt_g;
   logic        ghr_b;
   logic [3:0]  ghr_g;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
      .predict_taken(tk_b), .predict_hit(hit_b), .predict_target(tgt_b),
      .predict_ghr(ghr_b), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_ghr(upd_ghr1), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict)
   );

   branch_predictor #(.GHR_BITS(4)) dut_g (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
      .predict_taken(tk_g), .predict_hit(hit_g), .predict_target(tgt_g),
      .predict_ghr(ghr_g), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_ghr(upd_ghr4), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict)
   );

   // Reference model: [0] = bimodal instance, [1] = gshare (4-bit history).
   int          m_ctr [2][64];
   bit          m_vld [2][64];
   int          m_tag [2][64];
   logic [31:0] m_tgt [2][64];
   int          m_ghr [2];

   task automatic do_reset();
      rst = 1'b1;
      if_valid = 1'b0; if_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
      upd_taken = 1'b0; upd_target = 32'h0; upd_mispredict = 1'b0;
      upd_ghr1 = 1'b0; upd_ghr4 = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic [3:0] g, input logic mis);
      if_valid = 1'b0;
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      upd_ghr4 = g; upd_mispredict = mis;
      @(posedge clk); #1;
      upd_valid = 1'b0; upd_mispredict = 1'b0;
      #1;
   endtask

   function automatic logic [31:0] pick_pc();
      logic [31:0] p;
      p = 32'h0040_0000 + ($urandom_range(0, 15) << 2) + ($urandom_range(0, 1) << 8);
      return p;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      if_valid = 1'b1; if_pc = 32'h0040_0000; upd_valid = 1'b0; upd_mispredict = 1'b0;
      upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0; upd_ghr1 = 1'b0; upd_ghr4 = 4'h0;
      #12;
      total++; if (tk_b !== 1'b0) $display("FAIL reset_taken actual=%b required=0", tk_b); else passed++;
      total++; if (hit_b !== 1'b0) $display("FAIL reset_hit actual=%b required=0", hit_b); else passed++;
      total++; if (ghr_g !== 4'h0) $display("FAIL reset_ghr actual=%h required=0", ghr_g); else passed++;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      total++; if (hit_g !== 1'b0 || tk_g !== 1'b0) $display("FAIL post_reset_lookup actual=%b%b required=00", hit_g, tk_g); else passed++;
      total++; if (ghr_g !== 4'h0) $display("FAIL post_reset_ghr actual=%h required=0", ghr_g); else passed++;
      if_valid = 1'b0;
   endtask

   task automatic test_training();
      do_update(32'h0040_0010, 1'b1, 32'h0040_0040, 4'h0, 1'b0);
      do_update(32'h0040_0010, 1'b1, 32'h0040_0040, 4'h0, 1'b0);
      if_pc = 32'h0040_0010; #1;
      total++; if (hit_b !== 1'b1) $display("FAIL train_hit actual=%b required=1", hit_b); else passed++;
      total++; if (tk_b !== 1'b1) $display("FAIL train_taken actual=%b required=1", tk_b); else passed++;
      total++; if (tgt_b !== 32'h0040_0040) $display("FAIL train_target actual=%h required=00400040", tgt_b); else passed++;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) do_update(32'h0040_0010, 1'b1, 32'h0040_0040, 4'h0, 1'b0);
      if_pc = 32'h0040_0010; #1;
      total++; if (tk_b !== 1'b1) $display("FAIL sat_taken actual=%b required=1", tk_b); else passed++;
      do_update(32'h0040_0010, 1'b0, 32'h0, 4'h0, 1'b0);
      if_pc = 32'h0040_0010; #1;
      total++; if (tk_b !== 1'b1) $display("FAIL sat_nt1_taken actual=%b required=1", tk_b); else passed++;
      do_update(32'h0040_0010, 1'b0, 32'h0, 4'h0, 1'b0);
      if_pc = 32'h0040_0010; #1;
      total++; if (tk_b !== 1'b0) $display("FAIL sat_nt2_taken actual=%b required=0", tk_b); else passed++;
      total++; if (hit_b !== 1'b1) $display("FAIL sat_nt2_hit actual=%b required=1", hit_b); else passed++;
   endtask

   task automatic test_alias();
      if_pc = 32'h0040_0110; #1;
      total++; if (hit_b !== 1'b0 || tk_b !== 1'b0) $display("FAIL alias_miss actual=%b%b required=00", hit_b, tk_b); else passed++;
      do_update(32'h0040_0110, 1'b1, 32'h0040_0200, 4'h0, 1'b0);
      if_pc = 32'h0040_0010; #1;
      total++; if (hit_b !== 1'b0) $display("FAIL alias_evict_hit actual=%b required=0", hit_b); else passed++;
      if_pc = 32'h0040_0110; #1;
      total++; if (hit_b !== 1'b1) $display("FAIL alias_new_hit actual=%b required=1", hit_b); else passed++;
      total++; if (tgt_b !== 32'h0040_0200) $display("FAIL alias_new_target actual=%h required=00400200", tgt_b); else passed++;
      // Shared counter went 01 -> 10 with the taken update.
      total++; if (tk_b !== 1'b1) $display("FAIL alias_new_taken actual=%b required=1", tk_b); else passed++;
   endtask

   task automatic test_gshare_repair();
      do_reset();
      do_update(32'h0040_0010, 1'b1, 32'h0040_0100, 4'h0, 1'b0);
      do_update(32'h0040_0010, 1'b1, 32'h0040_0100, 4'h0, 1'b0);
      do_update(32'h0040_0020, 1'b1, 32'h0040_0300, 4'h2, 1'b0);
      do_update(32'h0040_0020, 1'b1, 32'h0040_0300, 4'h2, 1'b0);
      total++; if (ghr_g !== 4'h0) $display("FAIL gs_ghr_hold actual=%h required=0", ghr_g); else passed++;
      if_valid = 1'b1; if_pc = 32'h0040_0010; #1;
      total++; if (tk_g !== 1'b1) $display("FAIL gs_look1 actual=%b required=1", tk_g); else passed++;
      @(posedge clk); #1; if_pc = 32'h0040_0030; #1;
      total++; if (tk_g !== 1'b0 || ghr_g !== 4'h1) $display("FAIL gs_look2 actual=%b/%h required=0/1", tk_g, ghr_g); else passed++;
      @(posedge clk); #1; if_pc = 32'h0040_0020; #1;
      total++; if (tk_g !== 1'b1 || ghr_g !== 4'h2) $display("FAIL gs_look3 actual=%b/%h required=1/2", tk_g, ghr_g); else passed++;
      @(posedge clk); #1;
      total++; if (ghr_g !== 4'b0101) $display("FAIL gs_spec_ghr actual=%b required=0101", ghr_g); else passed++;
      if_pc = 32'h0040_0010;
      upd_valid = 1'b1; upd_mispredict = 1'b1; upd_ghr4 = 4'b0101; upd_taken = 1'b0;
      upd_pc = 32'h0040_0030; upd_target = 32'h0;
      @(posedge clk); #1;
      if_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; #1;
      total++; if (ghr_g !== 4'b1010) $display("FAIL gs_repair actual=%b required=1010", ghr_g); else passed++;
   endtask

   task automatic test_conflict_async_reset();
      do_reset();
      do_update(32'h0040_0080, 1'b1, 32'h0040_0500, 4'h0, 1'b0);
      if_valid = 1'b1; if_pc = 32'h0040_0080;
      upd_valid = 1'b1; upd_pc = 32'h0040_0080; upd_taken = 1'b0; upd_ghr4 = 4'h0;
      #1;
      total++; if (tk_b !== 1'b1) $display("FAIL conflict_old actual=%b required=1", tk_b); else passed++;
      @(posedge clk); #1;
      upd_valid = 1'b0; if_valid = 1'b0; #1;
      total++; if (tk_b !== 1'b0) $display("FAIL conflict_new actual=%b required=0", tk_b); else passed++;
      do_update(32'h0040_0080, 1'b1, 32'h0040_0500, 4'h0, 1'b1);
      if_pc = 32'h0040_0080;
      @(posedge clk); #3;
      total++; if (hit_b !== 1'b1 || ghr_g !== 4'h1) $display("FAIL pre_async actual=%b/%h required=1/1", hit_b, ghr_g); else passed++;
      rst = 1'b1; #1;
      total++; if (hit_b !== 1'b0 || tk_b !== 1'b0) $display("FAIL async_hit actual=%b%b required=00", hit_b, tk_b); else passed++;
      total++; if (ghr_g !== 4'h0) $display("FAIL async_ghr actual=%h required=0", ghr_g); else passed++;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_random();
      int idx, pi, tg, g, ui, e_hit, e_tk;
      logic a_hit [2];
      logic a_tk [2];
      logic [31:0] a_tgt [2];
      int a_ghr [2];
      int p_tk [2];
      do_reset();
      for (int k = 0; k < 2; k++) begin
         m_ghr[k] = 0;
         for (int e = 0; e < 64; e++) begin m_ctr[k][e] = 1; m_vld[k][e] = 0; m_tag[k][e] = 0; m_tgt[k][e] = 0; end
      end
      for (int n = 0; n < 300; n++) begin
         if_valid = 1'($urandom_range(0, 1));
         if_pc = if_valid ? pick_pc() : 32'hxxxx_xxxx;
         upd_valid = ($urandom_range(0, 2) != 0);
         upd_pc = pick_pc();
         upd_taken = 1'($urandom_range(0, 1));
         upd_target = $urandom & 32'hffff_fffc;
         upd_mispredict = 1'($urandom_range(0, 1));
         upd_ghr4 = 4'($urandom_range(0, 15));
         #1;
         a_hit[0] = hit_b; a_tk[0] = tk_b; a_tgt[0] = tgt_b; a_ghr[0] = int'(ghr_b);
         a_hit[1] = hit_g; a_tk[1] = tk_g; a_tgt[1] = tgt_g; a_ghr[1] = int'(ghr_g);
         for (int k = 0; k < 2; k++) begin
            p_tk[k] = 0;
            total++; if (a_ghr[k] !== m_ghr[k]) $display("FAIL rand_ghr%0d n=%0d actual=%0d required=%0d", k, n, a_ghr[k], m_ghr[k]); else passed++;
            if (if_valid) begin
               idx = (if_pc / 4) % 64;
               tg  = (if_pc / 256) % 256;
               pi  = idx ^ m_ghr[k];
               e_hit = (m_vld[k][idx] && m_tag[k][idx] == tg) ? 1 : 0;
               e_tk  = (e_hit == 1 && m_ctr[k][pi] >= 2) ? 1 : 0;
               p_tk[k] = e_tk;
               total++; if (a_hit[k] !== 1'(e_hit)) $display("FAIL rand_hit%0d n=%0d actual=%b required=%0d", k, n, a_hit[k], e_hit); else passed++;
               total++; if (a_tk[k] !== 1'(e_tk)) $display("FAIL rand_taken%0d n=%0d actual=%b required=%0d", k, n, a_tk[k], e_tk); else passed++;
               if (e_hit == 1) begin
                  total++; if (a_tgt[k] !== m_tgt[k][idx]) $display("FAIL rand_target%0d n=%0d actual=%h required=%h", k, n, a_tgt[k], m_tgt[k][idx]); else passed++;
               end
            end
         end
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            g = (k == 1) ? int'(upd_ghr4) : 0;
            if (upd_valid) begin
               idx = (upd_pc / 4) % 64;
               ui  = idx ^ g;
               if (upd_taken) begin
                  m_ctr[k][ui] = (m_ctr[k][ui] < 3) ? m_ctr[k][ui] + 1 : 3;
                  m_vld[k][idx] = 1; m_tag[k][idx] = (upd_pc / 256) % 256; m_tgt[k][idx] = upd_target;
               end else begin
                  m_ctr[k][ui] = (m_ctr[k][ui] > 0) ? m_ctr[k][ui] - 1 : 0;
               end
            end
            if (k == 1) begin
               if (upd_valid && upd_mispredict) m_ghr[1] = (g * 2 + int'(upd_taken)) % 16;
               else if (if_valid) m_ghr[1] = (m_ghr[1] * 2 + p_tk[1]) % 16;
            end
         end
         #1;
      end
      if_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; if_pc = 32'h0;
   endtask

   initial begin
      test_reset();
      test_training();
      test_saturation();
      test_alias();
      test_gshare_repair();
      test_conflict_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic branch predictor for the IF stage. It replaces the external single-bit predict_signal and the IMM-based taken target used by the NPC mux. It holds a pattern history table (PHT) of saturating counters, a tagged branch target buffer (BTB) and an optional global history register (GHR, gshare mode). Branches resolve in ID/EX and train the tables through an update port; mispredicts repair the GHR.

Parameters:
ENTRIES, 64, number of PHT and BTB entries; power of two, >=4; IDX_W = log2(ENTRIES)
CTR_BITS, 2, PHT saturating counter width, 1..4
TAG_BITS, 8, BTB tag width, 1..(30-IDX_W)
GHR_BITS, 0, global history length; 0 = bimodal, 1..IDX_W = gshare

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_valid  in  1  IF holds a branch-class instruction this cycle and IF is not stalled
if_pc  in  32  PC being fetched
predict_taken  out  1  predicted taken (combinational from tables)
predict_hit  out  1  BTB hit for if_pc
predict_target  out  32  BTB target; valid only when predict_hit=1
predict_ghr  out  max(GHR_BITS,1)  GHR snapshot used for this lookup; carried down the pipe
upd_valid  in  1  a branch resolved this cycle
upd_pc  in  32  PC of the resolved branch
upd_ghr  in  max(GHR_BITS,1)  predict_ghr captured at that branch's lookup
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken target
upd_mispredict  in  1  prediction was wrong; qualified by upd_valid

Behaviour:
- Index and tag:
  - btb_idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_BITS+1:IDX_W+2].
  - pht_idx = btb_idx XOR {zero-extended GHR} when GHR_BITS>0, otherwise btb_idx.
  - Lookup uses the current GHR. Update uses upd_ghr.
- Lookup outputs are purely combinational:
  - predict_hit = btb_valid[idx] & (btb_tag[idx]==tag).
  - predict_taken = predict_hit & counter MSB.
  - predict_target = btb_target[idx].
  - predict_ghr = GHR.
- Reset, asynchronous, takes effect immediately:
  - All BTB valid bits = 0.
  - All counters = 2^(CTR_BITS-1)-1 (weakly not-taken); this is 0 when CTR_BITS=1.
  - GHR = 0.
  - Hence predict_taken=0, predict_hit=0 and predict_ghr=0 while rst is high and after release until training.
  - Reset mid-training discards all state; there is no partial preservation.
- Update (posedge clk, upd_valid=1):
  - Counter: if upd_taken, increment and saturate at 2^CTR_BITS-1; otherwise decrement and saturate at 0.
  - BTB on upd_taken=1: write tag, upd_target, valid=1, overwriting any alias.
  - BTB on upd_taken=0: unchanged.
- GHR (GHR_BITS>0), priority order:
  1. upd_valid & upd_mispredict: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken} (the repair). Any same-cycle speculative shift is discarded.
  2. Else if if_valid: GHR <= {GHR[GHR_BITS-2:0], predict_taken} (speculative).
  3. Else hold.
  - When GHR_BITS=1, the shift degenerates to a single bit.
  - When GHR_BITS=0, the GHR is a constant 0 and predict_ghr=0.
- Simultaneous lookup and update to the same entry: the lookup sees the pre-update value. There is no write-through bypass; the new value is visible the next cycle.
- No state changes when upd_valid=0 and if_valid=0.
- upd_mispredict without upd_valid is ignored.
- X on if_pc while if_valid=0 must not corrupt state.

Test Plan:
1. Reset, then lookup (defaults): if_pc=0x00400000, if_valid=1 -> predict_taken=0, predict_hit=0, predict_ghr=0.
2. Training (GHR_BITS=0): two updates for pc=0x00400010, taken=1, target=0x00400040 (counter 01->10->11). Lookup 0x00400010 -> hit=1, taken=1, target=0x00400040.
3. Saturation: 3 further taken updates keep the counter at 11. One not-taken update -> 10, still predicted taken. Second not-taken -> 01, predict_taken=0, hit stays 1.
4. Tag alias: after test 2, lookup 0x00400110 (same idx 4, different tag) -> hit=0, taken=0. A taken update for 0x00400110 with target 0x00400200 evicts the entry; lookup 0x00400010 -> hit=0.
5. Gshare GHR repair (GHR_BITS=4): three if_valid lookups predicted taken/not/taken from GHR=0 -> GHR=4'b0101. Same cycle: if_valid=1 plus upd_valid=1, upd_mispredict=1, upd_ghr=4'b0101, upd_taken=0 -> GHR=4'b1010 (repair wins).
6. Same-cycle conflict and async reset: an update and a lookup to the same idx in one cycle -> the lookup shows the old counter, the new value appears next cycle. Assert rst between clock edges -> predict_hit=0 and predict_ghr=0 immediately, without waiting for a clock.
